// File: rtl/bitwise_reduce_pkg.sv
// Shared encodings for the bitwise reduction engine.
// Op and FSM state enums plus the fold identity helper.
package bitwise_reduce_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Fill bit of the fold identity: ones for AND, zeros otherwise.
  function automatic logic ident_bit(op_e op);
    return op == OP_AND;
  endfunction

endpackage

// File: rtl/bitwise_reduce_if.sv
// Operand and result valid/ready channels of bitwise_reduce.
// master drives operands and takes results; slave is the engine.
interface bitwise_reduce_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/bitwise_reduce_op.sv
// bitwise_op: WIDTH-wide two-operand gate (OR/AND/XOR/NOR).
// Purely combinational, no carries between bits.
module bitwise_op
  import bitwise_reduce_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = '0;
    unique case (op)
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/bitwise_reduce.sv
// Streaming OR/AND/XOR/NOR reduction of a burst of words.
// Optional abort input under `BITWISE_REDUCE_ABORT_EN.
module bitwise_reduce
  import bitwise_reduce_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MAX_LEN = 16,
  parameter int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [CW-1:0] len,
`ifdef BITWISE_REDUCE_ABORT_EN
  input  logic          abort,
`endif
  bitwise_reduce_if.slave bus,
  output logic          busy
);
  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    len_q, len_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] fold;
  logic [CW-1:0]    len_sat;
  op_e              op_in;
  op_e              fold_op;

  assign op_in   = op_e'(op);
  assign len_sat = (len > CW'(MAX_LEN)) ? CW'(MAX_LEN) : len;
  // NOR accumulates as OR; the inversion is applied once at the end.
  assign fold_op = (op_q == OP_NOR) ? OP_OR : op_q;

  bitwise_op #(.WIDTH(WIDTH)) u_op (
    .a  (acc_q),
    .b  (bus.in_data),
    .op (fold_op),
    .y  (fold)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_OR;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op_in;
          len_d = len_sat;
          acc_d = {WIDTH{ident_bit(op_in)}};
          cnt_d = '0;
          if (len_sat == '0) begin
            state_d = S_DONE;
            out_d   = acc_d ^ {WIDTH{op_in == OP_NOR}};
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (bus.in_valid) begin
          acc_d = fold;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == len_q - CW'(1)) begin
            state_d = S_DONE;
            out_d   = fold ^ {WIDTH{op_q == OP_NOR}};
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef BITWISE_REDUCE_ABORT_EN
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      out_d   = out_q;
    end
`endif
  end

  assign bus.in_ready  = state_q == S_RUN;
  assign bus.out_valid = state_q == S_DONE;
  assign bus.out_data  = out_q;
  assign busy          = state_q != S_IDLE;

endmodule

// File: tb/tb_bitwise_reduce.sv
// Directed self-checking bench for bitwise_reduce.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_bitwise_reduce;
  localparam int W  = 16;
  localparam int ML = 16;
  localparam int CW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [CW-1:0] len;
  logic          busy;
`ifdef BITWISE_REDUCE_ABORT_EN
  logic          abort;
`endif
  int checks = 0;
  int errors = 0;

  bitwise_reduce_if #(.WIDTH(W)) bus ();

  bitwise_reduce #(.WIDTH(W), .MAX_LEN(ML)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .len   (len),
`ifdef BITWISE_REDUCE_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [1:0] o, input logic [CW-1:0] l);
    start = 1'b1;
    op    = o;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [W-1:0] d);
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic take(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic result(input string tag, input logic [W-1:0] exp);
    chk({tag, "_ov"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_dat"}, 32'(bus.out_data), 32'(exp));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef BITWISE_REDUCE_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ir", 32'(bus.in_ready), 32'd0);
    chk("rst_ov", 32'(bus.out_valid), 32'd0);
    chk("rst_dat", 32'(bus.out_data), 32'd0);
    tick();

    // OR of complementary patterns
    go(2'b00, CW'(2));
    chk("or_busy", 32'(busy), 32'd1);
    beat("or_b1", 16'hAAAA);
    chk("or_ov_early", 32'(bus.out_valid), 32'd0);
    beat("or_b2", 16'h5555);
    result("or", 16'hFFFF);
    chk("or_ir_done", 32'(bus.in_ready), 32'd0);
    take("or");

    // AND with gaps; in_ready stays high during RUN
    go(2'b01, CW'(3));
    beat("and_b1", 16'hFFFF);
    for (int i = 0; i < 2; i++) begin
      chk("and_gap_ir", 32'(bus.in_ready), 32'd1);
      tick();
    end
    beat("and_b2", 16'h0F0F);
    for (int i = 0; i < 2; i++) begin
      chk("and_gap_ir", 32'(bus.in_ready), 32'd1);
      tick();
    end
    beat("and_b3", 16'h3C3C);
    result("and", 16'h0C0C);
    take("and");

    // XOR with back-pressure and a stray start in DONE
    go(2'b10, CW'(2));
    beat("xor_b1", 16'h1234);
    beat("xor_b2", 16'h9876);
    for (int i = 0; i < 5; i++) begin
      result("xor_hold", 16'h8A42);
      start = (i == 2);
      op    = 2'b00;
      len   = CW'(1);
      tick();
    end
    start = 1'b0;
    result("xor_post", 16'h8A42);
    take("xor");
    chk("xor_ir_idle", 32'(bus.in_ready), 32'd0);
    chk("xor_ov_idle", 32'(bus.out_valid), 32'd0);

    // Zero-length bursts
    go(2'b00, CW'(0));
    chk("or0_ir", 32'(bus.in_ready), 32'd0);
    result("or0", 16'h0000);
    take("or0");
    go(2'b11, CW'(0));
    chk("nor0_ir", 32'(bus.in_ready), 32'd0);
    result("nor0", 16'hFFFF);
    take("nor0");

    // Full-length AND
    go(2'b01, CW'(16));
    for (int i = 0; i < 15; i++) beat("and16", 16'hFFFF);
    chk("and16_ov_early", 32'(bus.out_valid), 32'd0);
    beat("and16_last", 16'h8001);
    result("and16", 16'h8001);
    take("and16");

    // Oversized length saturates to 16 beats
    go(2'b01, CW'(20));
    for (int i = 0; i < 15; i++) beat("sat", 16'hFFFF);
    chk("sat_ov_early", 32'(bus.out_valid), 32'd0);
    beat("sat_last", 16'h00F0);
    result("sat", 16'h00F0);
    chk("sat_ir", 32'(bus.in_ready), 32'd0);
    take("sat");

    // Reset mid-burst, then a clean burst
    go(2'b00, CW'(3));
    beat("rr_b1", 16'hFF00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_ir", 32'(bus.in_ready), 32'd0);
    chk("rr_ov", 32'(bus.out_valid), 32'd0);
    tick();
    go(2'b00, CW'(1));
    beat("rr_b", 16'h0001);
    result("rr", 16'h0001);
    take("rr");

    // NOR over two beats
    go(2'b11, CW'(2));
    beat("nor_b1", 16'h00F0);
    beat("nor_b2", 16'h0F00);
    result("nor", 16'hF00F);
    take("nor");

`ifdef BITWISE_REDUCE_ABORT_EN
    go(2'b00, CW'(1));
    beat("ab_b", 16'h1111);
    result("ab", 16'h1111);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_ov", 32'(bus.out_valid), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    go(2'b00, CW'(2));
    abort = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    abort = 1'b0;
    bus.in_valid = 1'b0;
    chk("ab_run_ir", 32'(bus.in_ready), 32'd0);
    chk("ab_run_busy", 32'(busy), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
